// File: rtl/seq_shift_left_unit_if.sv
// rtl/seq_shift_left_unit_if.sv - start/busy/done handshake and operand/result bundle for the shift engine
//   master: drives start, sel0, sel1, x, cin, amt; observes f, cout, overflow, busy, done
//   slave : the shift engine itself
interface seq_shift_left_unit_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             start;
    logic             sel0;
    logic             sel1;
    logic [WIDTH-1:0] x;
    logic             cin;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, sel0, sel1, x, cin, amt,
        input  f, cout, overflow, busy, done
    );

    modport slave (
        input  start, sel0, sel1, x, cin, amt,
        output f, cout, overflow, busy, done
    );
endinterface

// File: rtl/seq_shift_left_unit.sv
// rtl/seq_shift_left_unit.sv - multi-cycle left shifter, one bit position per clock, four modes
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of seq_shift_left_unit_if
//              start/sel1/sel0/x/cin/amt in; f (result), cout (carry), overflow (sticky),
//              busy (shifting), done (one-cycle result-valid pulse) out
module seq_shift_left_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_shift_left_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LOGICAL = 2'b00;
    localparam logic [1:0] MODE_ROTATE  = 2'b01;
    localparam logic [1:0] MODE_CARRY   = 2'b10;
    localparam logic [1:0] MODE_ARITH   = 2'b11;

    state_t           state_r, state_n;
    logic [WIDTH-1:0] f_r, f_n;
    logic             c_r, c_n;
    logic             ovf_r, ovf_n;
    logic [AMT_W-1:0] cnt_r, cnt_n;
    logic [1:0]       mode_r, mode_n;
    logic             msb;
    logic             fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            f_r     <= '0;
            c_r     <= 1'b0;
            ovf_r   <= 1'b0;
            cnt_r   <= '0;
            mode_r  <= MODE_LOGICAL;
        end else begin
            state_r <= state_n;
            f_r     <= f_n;
            c_r     <= c_n;
            ovf_r   <= ovf_n;
            cnt_r   <= cnt_n;
            mode_r  <= mode_n;
        end
    end

    always_comb begin
        state_n = state_r;
        f_n     = f_r;
        c_n     = c_r;
        ovf_n   = ovf_r;
        cnt_n   = cnt_r;
        mode_n  = mode_r;
        msb     = f_r[WIDTH-1];

        // Bit shifted into the LSB: the old MSB for rotate, the carry for
        // the (WIDTH+1)-bit through-carry rotate, zero otherwise.
        case (mode_r)
            MODE_ROTATE: fill = msb;
            MODE_CARRY:  fill = c_r;
            default:     fill = 1'b0;
        endcase

        case (state_r)
            IDLE, DONE: begin
                // DONE falls back to IDLE unless a new operation is accepted
                // right away, which gives the amt+2 back-to-back period.
                state_n = IDLE;
                if (bus.start) begin
                    state_n = SHIFT;
                    f_n     = bus.x;
                    cnt_n   = bus.amt;
                    mode_n  = {bus.sel1, bus.sel0};
                    c_n     = ({bus.sel1, bus.sel0} == MODE_CARRY) ? bus.cin : 1'b0;
                    ovf_n   = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt_r != '0) begin
                    f_n   = {f_r[WIDTH-2:0], fill};
                    c_n   = msb;
                    cnt_n = cnt_r - AMT_W'(1);
                    // Sign change on this step means the signed value no
                    // longer fits; the flag is sticky for the operation.
                    if (mode_r == MODE_ARITH) begin
                        ovf_n = ovf_r | (f_r[WIDTH-1] ^ f_r[WIDTH-2]);
                    end
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.f        = f_r;
    assign bus.cout     = c_r;
    assign bus.overflow = ovf_r;
    assign bus.busy     = (state_r == SHIFT);
    assign bus.done     = (state_r == DONE);

endmodule

// File: tb/tb_seq_shift_left_unit.sv
// tb/tb_seq_shift_left_unit.sv - scoreboard bench for seq_shift_left_unit
module tb_seq_shift_left_unit;

    localparam int W  = 8;
    localparam int AW = 3;

    typedef struct {
        string        tag;
        logic [W-1:0] f;
        logic         c;
        logic         o;
        int           amt;
        int           acc;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    sb_t  sb[$];
    sb_t  mon_e;

    seq_shift_left_unit_if #(.WIDTH(W), .AMT_W(AW)) sif ();

    seq_shift_left_unit #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model written from the closed-form behaviour, not the step loop.
    function automatic void model(input logic [1:0] md, input logic [W-1:0] xv, input logic ci,
                                  input int a, output logic [W-1:0] ef, output logic ec,
                                  output logic eo);
        logic [2*W+8-1:0] wide;
        logic [W:0]       v;
        int               k;
        logic             b;
        eo = 1'b0;
        ef = '0;
        ec = 1'b0;
        case (md)
            2'b00, 2'b11: begin
                wide = {{(W+8){1'b0}}, xv} << a;
                ef   = wide[W-1:0];
                ec   = (a == 0) ? 1'b0 : ((a <= W) ? xv[W-a] : 1'b0);
                if (md == 2'b11) begin
                    for (int j = 1; j <= a; j++) begin
                        b = (W - 1 - j >= 0) ? xv[W-1-j] : 1'b0;
                        if (b != xv[W-1]) eo = 1'b1;
                    end
                end
            end
            2'b01: begin
                k  = a % W;
                ef = (xv << k) | (xv >> (W - k));
                ec = (a == 0) ? 1'b0 : ef[0];
            end
            default: begin
                v = {ci, xv};
                k = a % (W + 1);
                for (int j = 0; j < k; j++) v = {v[W-1:0], v[W]};
                ef = v[W-1:0];
                ec = v[W];
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && sif.done) begin
            chk("busy_with_done", {31'b0, sif.busy}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, "_f"},       {24'b0, sif.f},       {24'b0, mon_e.f});
                chk({mon_e.tag, "_cout"},    {31'b0, sif.cout},    {31'b0, mon_e.c});
                chk({mon_e.tag, "_ovf"},     {31'b0, sif.overflow},{31'b0, mon_e.o});
                chk({mon_e.tag, "_latency"}, cyc - mon_e.acc,      mon_e.amt + 1);
            end
        end
    end

    // Called at a negedge with the DUT in IDLE or DONE; returns one negedge later.
    task automatic issue(input string tag, input logic [1:0] md, input logic [W-1:0] xv,
                         input logic ci, input int a, input logic [W-1:0] ef,
                         input logic ec, input logic eo);
        sb_t e;
        sif.start = 1'b1;
        sif.sel1  = md[1];
        sif.sel0  = md[0];
        sif.x     = xv;
        sif.cin   = ci;
        sif.amt   = AW'(a);
        e.tag = tag; e.f = ef; e.c = ec; e.o = eo; e.amt = a; e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        sif.start = 1'b0;
        sif.x     = W'($urandom);
        sif.sel0  = 1'($urandom);
        sif.sel1  = 1'($urandom);
        sif.cin   = 1'($urandom);
        sif.amt   = AW'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!sif.done && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!sif.done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run(input string tag, input logic [1:0] md, input logic [W-1:0] xv,
                       input logic ci, input int a, input logic [W-1:0] ef,
                       input logic ec, input logic eo);
        issue(tag, md, xv, ci, a, ef, ec, eo);
        wait_done(tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, sif.done}, 32'd0);
    endtask

    logic [W-1:0] mf;
    logic         mc, mo;
    logic [1:0]   rmd;
    logic [W-1:0] rx;
    logic         rci;
    int           ra;

    initial begin
        sif.start = 1'b0; sif.sel0 = 1'b0; sif.sel1 = 1'b0;
        sif.x = '0; sif.cin = 1'b0; sif.amt = '0;
        repeat (3) @(negedge clk);
        chk("rst_f",    {24'b0, sif.f},        32'd0);
        chk("rst_cout", {31'b0, sif.cout},     32'd0);
        chk("rst_ovf",  {31'b0, sif.overflow}, 32'd0);
        chk("rst_busy", {31'b0, sif.busy},     32'd0);
        chk("rst_done", {31'b0, sif.done},     32'd0);
        rst = 1'b0;
        @(negedge clk);

        run("logical_a1",  2'b00, 8'b1000_0001, 1'b0, 1, 8'b0000_0010, 1'b1, 1'b0);
        run("rotate_a3",   2'b01, 8'b1000_0001, 1'b0, 3, 8'b0000_1100, 1'b0, 1'b0);
        run("rotate_a9",   2'b01, 8'b1000_0001, 1'b0, 9 % 8, 8'b0000_0011, 1'b1, 1'b0);
        run("carry_a2",    2'b10, 8'h80, 1'b1, 2, 8'h03, 1'b0, 1'b0);
        run("carry_a0",    2'b10, 8'h80, 1'b1, 0, 8'h80, 1'b1, 1'b0);
        run("logic_a0",    2'b00, 8'h80, 1'b1, 0, 8'h80, 1'b0, 1'b0);
        run("arith_40",    2'b11, 8'h40, 1'b0, 1, 8'h80, 1'b0, 1'b1);
        run("arith_c0",    2'b11, 8'hC0, 1'b0, 1, 8'h80, 1'b1, 1'b0);
        run("arith_20",    2'b11, 8'h20, 1'b0, 2, 8'h80, 1'b0, 1'b1);
        run("arith_sticky",2'b11, 8'h20, 1'b0, 5, 8'h00, 1'b0, 1'b1);
        run("logical_a7",  2'b00, 8'hFF, 1'b0, 7, 8'h80, 1'b1, 1'b0);
        run("carry_a7",    2'b10, 8'h01, 1'b0, 7, 8'h80, 1'b0, 1'b0);

        // start pulsed mid-operation must be ignored
        issue("ignore_start", 2'b00, 8'h0F, 1'b0, 5, 8'hE0, 1'b1, 1'b0);
        @(negedge clk);
        sif.start = 1'b1; sif.sel1 = 1'b1; sif.sel0 = 1'b1; sif.x = 8'hFF; sif.amt = 3'd1;
        @(negedge clk);
        sif.start = 1'b0;
        wait_done("ignore_start");
        repeat (4) @(negedge clk);
        chk("ignore_start_no_extra", sb.size(), 32'd0);

        // back-to-back: start held in the DONE cycle
        issue("b2b_first", 2'b01, 8'b1000_0001, 1'b0, 3, 8'b0000_1100, 1'b0, 1'b0);
        wait_done("b2b_first");
        issue("b2b_second", 2'b11, 8'h40, 1'b0, 1, 8'h80, 1'b0, 1'b1);
        wait_done("b2b_second");
        @(negedge clk);

        // reset during an amt=7 operation
        issue("rst_mid", 2'b00, 8'hFF, 1'b0, 7, 8'h80, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("rstmid_f",    {24'b0, sif.f},        32'd0);
        chk("rstmid_cout", {31'b0, sif.cout},     32'd0);
        chk("rstmid_ovf",  {31'b0, sif.overflow}, 32'd0);
        chk("rstmid_busy", {31'b0, sif.busy},     32'd0);
        chk("rstmid_done", {31'b0, sif.done},     32'd0);
        repeat (12) @(negedge clk);
        run("after_rst", 2'b01, 8'hA5, 1'b0, 4, 8'h5A, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rmd = 2'($urandom);
            rx  = W'($urandom);
            rci = 1'($urandom);
            ra  = $urandom_range(0, 7);
            model(rmd, rx, rci, ra, mf, mc, mo);
            run($sformatf("rand%0d", i), rmd, rx, rci, ra, mf, mc, mo);
        end

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
